// File: rtl/oc8051_rom_arb_pkg.sv
// Shared types and defaults for the oc8051 ROM arbiter between the CPU fetch
// port and the boot verifier.
package oc8051_rom_arb_pkg;

  localparam int unsigned DEF_ADDR_W    = 16;
  localparam int unsigned DEF_DATA_W    = 32;
  localparam int unsigned DEF_MAX_BURST = 8;

  // Owner of the previous grant cycle
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CPU      = 2'd1,
    ST_VRF      = 2'd2,
    ST_VRF_LOCK = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VRF  = 2'd2
  } owner_e;

endpackage

// File: rtl/oc8051_rom_arb.sv
// Two-port arbiter in front of a combinational ROM: round-robin between CPU and
// boot verifier, with a bounded verifier burst lock so the CPU cannot starve.
module oc8051_rom_arb
  import oc8051_rom_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_data,
  input  logic              vrf_req,
  input  logic [ADDR_W-1:0] vrf_addr,
  input  logic              vrf_lock,
  output logic              vrf_ack,
  output logic [DATA_W-1:0] vrf_data,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  localparam int unsigned     CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  state_e           r_state;
  state_e           w_state_nxt;
  owner_e           r_last_grant;
  owner_e           w_win;
  logic [CNT_W-1:0] r_burst_cnt;
  logic [CNT_W-1:0] w_burst_nxt;
  logic             w_lock_hold;
  logic             r_cpu_ack;
  logic             r_vrf_ack;
  logic [DATA_W-1:0] r_cpu_data;
  logic [DATA_W-1:0] r_vrf_data;

  // Winner selection: lock holds the verifier until the CPU has waited MAX_BURST grants
  always_comb begin
    w_win       = OWN_NONE;
    w_lock_hold = (r_state == ST_VRF_LOCK) && vrf_req && vrf_lock;
    if (rst) begin
      w_win = OWN_NONE;
    end else if (w_lock_hold) begin
      if (cpu_req && (r_burst_cnt >= CNT_MAX)) begin
        w_win = OWN_CPU;
      end else begin
        w_win = OWN_VRF;
      end
    end else if (cpu_req && vrf_req) begin
      if (r_last_grant == OWN_CPU) begin
        w_win = OWN_VRF;
      end else begin
        w_win = OWN_CPU;
      end
    end else if (cpu_req) begin
      w_win = OWN_CPU;
    end else if (vrf_req) begin
      w_win = OWN_VRF;
    end else begin
      w_win = OWN_NONE;
    end
  end

  // Next state, burst counter and ROM address mux
  always_comb begin
    w_state_nxt = ST_IDLE;
    w_burst_nxt = r_burst_cnt;
    rom_addr    = {ADDR_W{1'b0}};
    case (w_win)
      OWN_CPU: begin
        w_state_nxt = ST_CPU;
        rom_addr    = cpu_addr;
      end
      OWN_VRF: begin
        w_state_nxt = vrf_lock ? ST_VRF_LOCK : ST_VRF;
        rom_addr    = vrf_addr;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        rom_addr    = {ADDR_W{1'b0}};
      end
    endcase
    // Saturating: only locked verifier grants that make the CPU wait count
    if ((w_win == OWN_CPU) || !vrf_lock || !vrf_req) begin
      w_burst_nxt = {CNT_W{1'b0}};
    end else if ((w_win == OWN_VRF) && cpu_req && (r_burst_cnt < CNT_MAX)) begin
      w_burst_nxt = r_burst_cnt + CNT_W'(1);
    end else begin
      w_burst_nxt = r_burst_cnt;
    end
  end

  // Arbitration state, ack pulses and per-requester data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= OWN_VRF;
      r_burst_cnt  <= {CNT_W{1'b0}};
      r_cpu_ack    <= 1'b0;
      r_vrf_ack    <= 1'b0;
      r_cpu_data   <= {DATA_W{1'b0}};
      r_vrf_data   <= {DATA_W{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_burst_cnt <= w_burst_nxt;
      r_cpu_ack   <= (w_win == OWN_CPU);
      r_vrf_ack   <= (w_win == OWN_VRF);
      if (w_win != OWN_NONE) begin
        r_last_grant <= w_win;
      end
      if (w_win == OWN_CPU) begin
        r_cpu_data <= rom_data;
      end
      if (w_win == OWN_VRF) begin
        r_vrf_data <= rom_data;
      end
    end
  end

  assign cpu_ack  = r_cpu_ack;
  assign vrf_ack  = r_vrf_ack;
  assign cpu_data = r_cpu_data;
  assign vrf_data = r_vrf_data;

endmodule

// File: doc/oc8051_rom_arb.md
OC8051_ROM_ARB -- requirements
Module: oc8051_rom_arb

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  ADDR_W  16  ROM address width
  DATA_W  32  ROM data width
  MAX_BURST  8  maximum consecutive locked verifier grants while the CPU waits
REQ-002 Ports, one per line: name  direction  width  meaning. Clock and reset come first.
  clk  in  1  single clock; all state on rising edge
  rst  in  1  reset; synchronous and active-high
  cpu_req  in  1  CPU fetch request; held with cpu_addr until cpu_ack
  cpu_addr  in  ADDR_W  CPU fetch address
  cpu_ack  out  1  one-cycle pulse; CPU access complete
  cpu_data  out  DATA_W  registered ROM word for CPU; valid with cpu_ack, held until next cpu_ack
  vrf_req  in  1  boot-verifier read request; held with vrf_addr until vrf_ack
  vrf_addr  in  ADDR_W  verifier read address
  vrf_lock  in  1  verifier burst lock; sampled with vrf_req
  vrf_ack  out  1  one-cycle pulse; verifier access complete
  vrf_data  out  DATA_W  registered ROM word for verifier; valid with vrf_ack, held until next vrf_ack
  rom_addr  out  ADDR_W  address to the combinational ROM
  rom_data  in  DATA_W  combinational ROM word for rom_addr, same cycle

Function
REQ-003 The block SHALL grant at most one requester per cycle; the winner is decided combinationally from the current-cycle requests and state.
REQ-004 rom_addr SHALL equal the winner's address in its grant cycle, and 0 when there is no winner.
REQ-005 In grant cycle N, rom_data SHALL be captured into the winner's data register, and the winner's ack SHALL be high in cycle N+1 only (latency 1).
REQ-006 A req still high in its ack cycle SHALL count as a new request, so one requester alone completes one access per cycle.
REQ-007 Plain arbitration SHALL be round-robin on the last_grant register (CPU/VRF): with both requesting, the requester not equal to last_grant wins.
REQ-008 With only one requester active, that requester SHALL win regardless of last_grant.
REQ-009 FSM states are IDLE, CPU, VRF, VRF_LOCK; the state is the owner of the previous grant cycle (IDLE = no grant).
REQ-010 Transitions to VRF_LOCK:
  - enter on a VRF grant with vrf_lock=1;
  - while in VRF_LOCK with vrf_req=1 and vrf_lock=1, the verifier SHALL win over cpu_req until burst_cnt reaches MAX_BURST;
  - then the CPU SHALL win the next cycle, burst_cnt clears, and the state goes to CPU.
REQ-011 burst_cnt SHALL increment only on a locked VRF grant while cpu_req=1.
  - It clears on any CPU grant, on vrf_lock=0, or on a cycle with no vrf_req.
  - Width is clog2(MAX_BURST+1); it never wraps.
REQ-012 Dropping vrf_lock or vrf_req SHALL leave VRF_LOCK immediately, and normal round-robin applies that cycle.
REQ-013 An ack pulse and a new grant to the other requester in the same cycle are legal; each data register is written only on its own grant.
REQ-014 Deasserting req before ack is a protocol violation; the block need not flag it, but SHALL still pulse ack for any grant already issued.

Reset
REQ-015 While rst=1 at a rising edge, the following SHALL be set:
  - cpu_ack=0, vrf_ack=0;
  - cpu_data=0, vrf_data=0;
  - state=IDLE, last_grant=VRF (CPU wins the first tie), burst_cnt=0.
REQ-016 No grant SHALL be issued in a cycle with rst=1; rom_addr=0 during reset.
REQ-017 A grant issued in the cycle before rst rises SHALL NOT produce an ack after reset; pending requests are re-arbitrated from reset state.

Structure
REQ-018 A shared package oc8051_rom_arb_pkg SHALL hold ADDR_W/DATA_W defaults, MAX_BURST default, the FSM state enum and the grant-owner enum.
REQ-019 The block SHALL be a single module with no sub-modules; the ROM itself is instantiated outside and connected via rom_addr/rom_data.

Verification
REQ-020 Single CPU requester:
  - stimulus: cpu_req=1 with addresses 0x0000, 0x0004, 0x0008 back-to-back;
  - response: cpu_ack high in three consecutive cycles, one cycle after each grant, with cpu_data = ROM[addr].
REQ-021 First tie after reset:
  - stimulus: both request from reset, cpu_addr=0x0010, vrf_addr=0x0100, held;
  - response: grants alternate CPU, VRF, CPU, VRF; rom_addr sequence 0x0010, 0x0100, 0x0010, 0x0100.
REQ-022 Burst lock with CPU waiting:
  - stimulus: vrf_req=1 and vrf_lock=1 from idle, cpu_req=1 one cycle later;
  - response: verifier receives exactly MAX_BURST=8 locked grants after cpu_req rises, then 1 CPU grant, then verifier resumes.
REQ-023 Lock release:
  - stimulus: vrf_lock drops after 3 locked grants with cpu_req=1;
  - response: the CPU wins the very next cycle and burst_cnt=0.
REQ-024 Reset mid-operation:
  - stimulus: assert rst in the grant cycle of vrf_addr=0x0200;
  - response: no vrf_ack follows; data registers read 0; the first post-reset tie goes to the CPU.
REQ-025 Idle: with no requests for 5 cycles, rom_addr=0 and both acks stay 0 throughout.
